uart_receiver: RTL and testbench

Serial-to-parallel receiver for the UART link; the receive-side counterpart of the block driving `TXD`. It samples `RXD` at the mid-point of each bit, recovers one 8N1 frame (start bit low, 8 data bits LSB first, stop bit high), and presents the byte with a valid/read handshake. Framing errors and overruns are flagged so the consumer can discard bad data.

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_sync.sv | 23 ++
 rtl/uart_receiver.sv | 132 +++++++++++++
 tb/tb_uart_receiver.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: frame geometry, line idle level and receiver FSM encoding.
package uart_pkg;

    localparam int unsigned DATA_BITS       = 8;
    localparam int unsigned IDX_W           = $clog2(DATA_BITS);
    localparam logic        UART_IDLE_LEVEL = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_STOP      = 3'd3,
        ST_WAIT_IDLE = 3'd4
    } uart_state_t;

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchronizer for a single asynchronous input with a selectable reset level.
module uart_sync #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver: mid-bit sampling, byte hand-off with valid/read handshake,
// framing-error pulse and sticky overrun flag.
module uart_receiver
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 RXD,
    input  logic                 rd,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 rx_busy,
    output logic                 frame_err,
    output logic                 overrun
);

    localparam int unsigned HALF  = CLKS_PER_BIT / 2;
    localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

    uart_state_t          state;
    logic [CNT_W-1:0]     cnt;
    logic [IDX_W-1:0]     bit_idx;
    logic [DATA_BITS-1:0] shift;
    logic                 rxd_s;

    uart_sync #(
        .RESET_VAL (UART_IDLE_LEVEL)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (RXD),
        .q     (rxd_s)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shift     <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            rx_busy   <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= 1'b0;

            // Consumer acknowledge; a good stop bit in the same cycle overrides below.
            if (rd && rx_valid) begin
                rx_valid <= 1'b0;
                overrun  <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    if (rxd_s != UART_IDLE_LEVEL) begin
                        state   <= ST_START;
                        cnt     <= '0;
                        rx_busy <= 1'b1;
                    end
                end

                ST_START: begin
                    if (cnt == CNT_HALF) begin
                        cnt <= '0;
                        if (rxd_s != UART_IDLE_LEVEL) begin
                            state   <= ST_DATA;
                            bit_idx <= '0;
                        end else begin
                            state   <= ST_IDLE;
                            rx_busy <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                ST_DATA: begin
                    if (cnt == CNT_LAST) begin
                        cnt     <= '0;
                        shift   <= {rxd_s, shift[DATA_BITS-1:1]};
                        bit_idx <= bit_idx + 1'b1;
                        if (bit_idx == IDX_LAST) begin
                            state <= ST_STOP;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                ST_STOP: begin
                    if (cnt == CNT_LAST) begin
                        cnt <= '0;
                        if (rxd_s == UART_IDLE_LEVEL) begin
                            rx_data  <= shift;
                            rx_valid <= 1'b1;
                            overrun  <= (rx_valid && !rd) ? 1'b1 : (rx_valid ? 1'b0 : overrun);
                            state    <= ST_IDLE;
                            rx_busy  <= 1'b0;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= ST_WAIT_IDLE;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                // Hold off until the line returns idle so a break is not seen as frames.
                ST_WAIT_IDLE: begin
                    if (rxd_s == UART_IDLE_LEVEL) begin
                        state   <= ST_IDLE;
                        rx_busy <= 1'b0;
                    end
                end

                default: begin
                    state   <= ST_IDLE;
                    rx_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver at 16 clocks per bit with hand-computed expectations.
module tb_uart_receiver;

    localparam int unsigned CPB = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic       RXD;
    logic       rd;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_busy;
    logic       frame_err;
    logic       overrun;

    int checks = 0;
    int errors = 0;

    // Per-frame observations, relative to E0 (edge index r within the frame)
    int         rise_rel;
    int         chg_rel;
    int         ferr_cnt;
    int         ferr_rel;
    logic       ovr_seen;
    logic [7:0] snap_data;
    logic       snap_valid;
    logic       snap_busy;
    logic       snap_ferr;
    logic       snap_ovr;

    int   glitch_ferr;
    logic glitch_busy_seen;

    always #5 clk = ~clk;

    uart_receiver #(
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .RXD       (RXD),
        .rd        (rd),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_busy   (rx_busy),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one frame; RXD for edge E0+r is set before that edge, outputs sampled #1 after it.
    task automatic send_frame(input logic [7:0] b, input logic stop, input int extra,
                              input int rd_rel, input int rst_rel, input int snap_rel);
        int   idx;
        logic prev_valid;
        logic [7:0] prev_data;
        rise_rel  = -1;
        chg_rel   = -1;
        ferr_cnt  = 0;
        ferr_rel  = -1;
        ovr_seen  = 1'b0;
        prev_valid = rx_valid;
        prev_data  = rx_data;
        for (int r = 0; r < 10 * int'(CPB) + extra; r++) begin
            idx = r / int'(CPB);
            if (idx == 0)      RXD = 1'b0;
            else if (idx <= 8) RXD = b[idx-1];
            else               RXD = stop;
            rd    = (r == rd_rel);
            reset = (r == rst_rel);
            tick();
            if (!prev_valid && rx_valid && rise_rel < 0) rise_rel = r;
            if (rx_data !== prev_data && chg_rel < 0)    chg_rel = r;
            if (frame_err) begin
                ferr_cnt++;
                if (ferr_rel < 0) ferr_rel = r;
            end
            if (overrun) ovr_seen = 1'b1;
            if (r == snap_rel) begin
                snap_data  = rx_data;
                snap_valid = rx_valid;
                snap_busy  = rx_busy;
                snap_ferr  = frame_err;
                snap_ovr   = overrun;
            end
            prev_valid = rx_valid;
            prev_data  = rx_data;
        end
        rd    = 1'b0;
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        RXD   = 1'b1;
        rd    = 1'b0;
        repeat (3) tick();
        check("rst_data",  32'(rx_data),   32'h00);
        check("rst_valid", 32'(rx_valid),  32'h0);
        check("rst_busy",  32'(rx_busy),   32'h0);
        check("rst_ferr",  32'(frame_err), 32'h0);
        check("rst_ovr",   32'(overrun),   32'h0);
        reset = 1'b0;
        repeat (4) tick();

        // 0xA5: valid rises at E0+154, busy high from E0+2
        send_frame(8'hA5, 1'b1, 0, -1, -1, 2);
        check("a5_rise",  32'(rise_rel), 32'd154);
        check("a5_data",  32'(rx_data),  32'hA5);
        check("a5_ferr",  32'(ferr_cnt), 32'd0);
        check("a5_ovr",   32'(ovr_seen), 32'h0);
        check("a5_busy2", 32'(snap_busy), 32'h1);
        check("a5_busy_end", 32'(rx_busy), 32'h0);

        // Start-bit glitch: 4 low cycles, then idle
        glitch_ferr = 0;
        glitch_busy_seen = 1'b0;
        RXD = 1'b0;
        repeat (4) begin
            tick();
            if (rx_busy) glitch_busy_seen = 1'b1;
        end
        RXD = 1'b1;
        repeat (20) begin
            tick();
            if (rx_busy) glitch_busy_seen = 1'b1;
            if (frame_err) glitch_ferr++;
        end
        check("gl_busy_seen", 32'(glitch_busy_seen), 32'h1);
        check("gl_busy_end",  32'(rx_busy),  32'h0);
        check("gl_valid",     32'(rx_valid), 32'h1);
        check("gl_data",      32'(rx_data),  32'hA5);
        check("gl_ferr",      32'(glitch_ferr), 32'd0);

        rd = 1'b1;
        tick();
        rd = 1'b0;
        check("rd_valid", 32'(rx_valid), 32'h0);
        check("rd_ovr",   32'(overrun),  32'h0);

        // 0x3C with low stop bit, line held low 20 extra cycles
        send_frame(8'h3C, 1'b0, 20, -1, -1, 154);
        check("fe_cnt",   32'(ferr_cnt),  32'd1);
        check("fe_rel",   32'(ferr_rel),  32'd154);
        check("fe_snap",  32'(snap_ferr), 32'h1);
        check("fe_nov",   32'(rise_rel),  32'hFFFFFFFF);
        check("fe_data",  32'(rx_data),   32'hA5);
        check("fe_wait",  32'(rx_busy),   32'h1);
        RXD = 1'b1;
        repeat (3) tick();
        check("fe_idle",  32'(rx_busy),   32'h0);
        send_frame(8'h55, 1'b1, 0, -1, -1, -1);
        check("f55_rise", 32'(rise_rel),  32'd154);
        check("f55_data", 32'(rx_data),   32'h55);
        rd = 1'b1;
        tick();
        rd = 1'b0;

        // Back-to-back 0x11, 0x22 without read -> overrun
        send_frame(8'h11, 1'b1, 0, -1, -1, -1);
        check("b11_data", 32'(rx_data),  32'h11);
        check("b11_ovr",  32'(overrun),  32'h0);
        send_frame(8'h22, 1'b1, 0, -1, -1, -1);
        check("b22_chg",  32'(chg_rel),  32'd154);
        check("b22_data", 32'(rx_data),  32'h22);
        check("b22_valid",32'(rx_valid), 32'h1);
        check("b22_ovr",  32'(overrun),  32'h1);
        rd = 1'b1;
        tick();
        rd = 1'b0;
        check("b_rd_valid", 32'(rx_valid), 32'h0);
        check("b_rd_ovr",   32'(overrun),  32'h0);

        // Read coincident with stop-bit sample of 0x77 while 0x66 pending with overrun set
        send_frame(8'h44, 1'b1, 0, -1, -1, -1);
        send_frame(8'h66, 1'b1, 0, -1, -1, -1);
        check("p66_ovr",  32'(overrun),   32'h1);
        send_frame(8'h77, 1'b1, 0, 154, -1, 154);
        check("c77_data", 32'(snap_data),  32'h77);
        check("c77_valid",32'(snap_valid), 32'h1);
        check("c77_ovr",  32'(snap_ovr),   32'h0);
        check("c77_end",  32'(rx_valid),   32'h1);

        // Reset pulse during data bit 4 of 0xF0
        send_frame(8'hF0, 1'b1, 0, -1, 85, 85);
        check("rs_data",  32'(snap_data),  32'h00);
        check("rs_valid", 32'(snap_valid), 32'h0);
        check("rs_busy",  32'(snap_busy),  32'h0);
        check("rs_ferr",  32'(snap_ferr),  32'h0);
        check("rs_ovr",   32'(snap_ovr),   32'h0);
        check("rs_after", 32'(rx_valid),   32'h0);
        send_frame(8'h0F, 1'b1, 0, -1, -1, -1);
        check("r0f_rise", 32'(rise_rel),  32'd154);
        check("r0f_data", 32'(rx_data),   32'h0F);
        check("r0f_ovr",  32'(overrun),   32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
